// File: rtl/ps2_pkg.sv
// Shared constants and read-FSM encoding for the PS/2 scan-code controller.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_GAP  = 2'd2
  } rd_state_t;

  function automatic logic is_err_code(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_scan_ctrl_if.sv
// Receiver-FIFO side of the scan controller: head byte, status and pop strobe.
interface ps2_scan_ctrl_if;
  logic       ready;
  logic [7:0] data;
  logic       overflow;
  logic       nextdata_n;

  modport master (input ready, input data, input overflow, output nextdata_n);
  modport slave  (output ready, output data, output overflow, input nextdata_n);
endinterface

// File: rtl/ps2_scan_ctrl.sv
// Pops bytes from the PS/2 receiver FIFO and turns E0/F0-prefixed scan codes
// into make events, held-key tracking and a press counter.
//
// state  | meaning
// S_IDLE | wait for ready, latch FIFO head into rx_byte
// S_POP  | nextdata_n low; rx_byte parsed on the exit edge
// S_GAP  | let receiver ready/data settle after the pop
module ps2_scan_ctrl
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  ps2_scan_ctrl_if.master  fifo,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_held,
  output logic             key_valid,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err,
  input  logic             clr_err
);

  rd_state_t        state, state_nx;
  logic [7:0]       rx_byte, rx_byte_nx;
  logic             ext_pend, ext_pend_nx;
  logic             brk_pend, brk_pend_nx;
  logic [7:0]       key_code_nx;
  logic             key_ext_nx, key_held_nx, key_valid_nx, err_nx;
  logic [CNT_W-1:0] press_cnt_nx;
  logic             same_key;

  // Pop strobe is a pure state decode so an async reset releases it at once.
  assign fifo.nextdata_n = (state != S_POP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rx_byte   <= 8'h00;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_held  <= 1'b0;
      key_valid <= 1'b0;
      press_cnt <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      rx_byte   <= rx_byte_nx;
      ext_pend  <= ext_pend_nx;
      brk_pend  <= brk_pend_nx;
      key_code  <= key_code_nx;
      key_ext   <= key_ext_nx;
      key_held  <= key_held_nx;
      key_valid <= key_valid_nx;
      press_cnt <= press_cnt_nx;
      err       <= err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    rx_byte_nx   = rx_byte;
    ext_pend_nx  = ext_pend;
    brk_pend_nx  = brk_pend;
    key_code_nx  = key_code;
    key_ext_nx   = key_ext;
    key_held_nx  = key_held;
    key_valid_nx = 1'b0;
    press_cnt_nx = press_cnt;
    err_nx       = err & ~clr_err;
    same_key     = (rx_byte == key_code) && (ext_pend == key_ext);

    case (state)
      S_IDLE: begin
        if (fifo.ready) begin
          rx_byte_nx = fifo.data;
          state_nx   = S_POP;
        end
      end
      S_POP: begin
        state_nx = S_GAP;
        if (rx_byte == PS2_EXT) begin
          ext_pend_nx = 1'b1;
        end else if (rx_byte == PS2_BRK) begin
          brk_pend_nx = 1'b1;
        end else begin
          ext_pend_nx = 1'b0;
          brk_pend_nx = 1'b0;
          if (is_err_code(rx_byte)) begin
            err_nx = 1'b1;
          end else if (brk_pend) begin
            if (same_key) key_held_nx = 1'b0;
          end else if (!(key_held && same_key)) begin
            // Typematic repeats of the held key fall through without an event.
            key_code_nx  = rx_byte;
            key_ext_nx   = ext_pend;
            key_held_nx  = 1'b1;
            key_valid_nx = 1'b1;
            press_cnt_nx = press_cnt + CNT_W'(1);
          end
        end
      end
      S_GAP:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    if (fifo.overflow) err_nx = 1'b1;
  end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Scoreboard bench: a queue-based FIFO model feeds the controller, a scan-code
// reference model predicts the state after every parsed byte.
module tb_ps2_scan_ctrl;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       held;
    logic       valid;
    logic [7:0] cnt;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_err;
  logic [7:0] key_code;
  logic       key_ext, key_held, key_valid, err;
  logic [7:0] press_cnt;

  always #5 clk = ~clk;

  ps2_scan_ctrl_if bus ();

  ps2_scan_ctrl #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo      (bus),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_held  (key_held),
    .key_valid (key_valid),
    .press_cnt (press_cnt),
    .err       (err),
    .clr_err   (clr_err)
  );

  logic [7:0] fifo_q[$];
  exp_t       exp_q[$];
  int         pop_cyc[$];
  int         checks, errors;
  int         pulses, exp_pulses;
  int         cyc;
  bit         pend_chk, prev_low;

  // reference model of the scan-code stream
  logic [7:0] m_code, m_cnt;
  logic       m_ext, m_held, m_err, m_ext_p, m_brk_p;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_code = 8'h00; m_cnt = 8'h00; m_ext = 1'b0; m_held = 1'b0;
    m_err = 1'b0; m_ext_p = 1'b0; m_brk_p = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    logic made;
    made = 1'b0;
    if (b == 8'hE0) m_ext_p = 1'b1;
    else if (b == 8'hF0) m_brk_p = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) begin
      m_err = 1'b1; m_ext_p = 1'b0; m_brk_p = 1'b0;
    end else begin
      if (m_brk_p) begin
        if (b == m_code && m_ext_p == m_ext) m_held = 1'b0;
      end else if (!(m_held && b == m_code && m_ext_p == m_ext)) begin
        m_code = b; m_ext = m_ext_p; m_held = 1'b1;
        m_cnt = m_cnt + 8'd1; made = 1'b1;
      end
      m_ext_p = 1'b0; m_brk_p = 1'b0;
    end
    if (made) exp_pulses++;
    e = '{code: m_code, ext: m_ext, held: m_held, valid: made, cnt: m_cnt, err: m_err};
    exp_q.push_back(e);
  endtask

  task automatic upd();
    bus.ready = (fifo_q.size() != 0);
    bus.data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // The receiver pops its head while the strobe is low.
  task automatic tick();
    @(negedge clk);
    if (!bus.nextdata_n && fifo_q.size() > 0) void'(fifo_q.pop_front());
    upd();
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    model_byte(b);
    upd();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (fifo_q.size() != 0 && n < 5000) begin
      tick();
      n++;
    end
    if (fifo_q.size() != 0) chk("drain_timeout", fifo_q.size(), 0);
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    model_reset();
    tick();
  endtask

  task automatic err_pulse(input logic ov, input logic clr);
    bus.overflow = ov;
    clr_err      = clr;
    tick();
    bus.overflow = 1'b0;
    clr_err      = 1'b0;
    if (ov) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] pool [10];
    logic [7:0] b;
    int p0;

    checks = 0; errors = 0; pulses = 0; exp_pulses = 0; cyc = 0;
    pend_chk = 1'b0; prev_low = 1'b0;
    pool = '{8'hE0, 8'hF0, 8'h1C, 8'h1C, 8'h75, 8'h15, 8'h1D, 8'h00, 8'hFF, 8'h5A};
    rst = 1'b1; clr_err = 1'b0; bus.overflow = 1'b0;
    model_reset();
    upd();

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (key_valid) pulses++;
        if (pend_chk) begin
          if (exp_q.size() == 0) chk("unexpected_parse", 1, 0);
          else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("key_code", key_code, e.code);
            chk("key_ext", key_ext, e.ext);
            chk("key_held", key_held, e.held);
            chk("key_valid", key_valid, e.valid);
            chk("press_cnt", press_cnt, e.cnt);
            chk("err", err, e.err);
          end
        end
        if (!bus.nextdata_n) begin
          chk("pop_not_back_to_back", prev_low, 0);
          pop_cyc.push_back(cyc);
        end
        pend_chk = !bus.nextdata_n;
        prev_low = !bus.nextdata_n;
      end
    join_none

    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_nextdata_n", bus.nextdata_n, 1);
    chk("rst_key_code", key_code, 0);
    chk("rst_key_held", key_held, 0);
    chk("rst_press_cnt", press_cnt, 0);
    chk("rst_err", err, 0);

    // single make
    pop_cyc.delete();
    push(8'h1C);
    drain();
    chk("single_pops", pop_cyc.size(), 1);
    chk("single_cnt", press_cnt, 1);
    chk("single_held", key_held, 1);

    // make, repeats, break: back-to-back drain at 3 cycles per byte
    do_reset();
    pop_cyc.delete();
    p0 = pulses;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    chk("rep_pulses", pulses - p0, 1);
    chk("rep_cnt", press_cnt, 1);
    chk("rep_held", key_held, 0);
    chk("rep_pops", pop_cyc.size(), 5);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("rep_byte_gap", pop_cyc[i] - pop_cyc[i-1], 3);

    // extended key; plain break must not release it
    push(8'hE0); push(8'h75);
    drain();
    chk("ext_code", key_code, 8'h75);
    chk("ext_flag", key_ext, 1);
    chk("ext_held", key_held, 1);
    push(8'hF0); push(8'h75);
    drain();
    chk("ext_plain_brk_held", key_held, 1);
    push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    chk("ext_brk_held", key_held, 0);

    // errors: pending prefixes dropped, set wins over clear
    push(8'hE0); push(8'hF0); push(8'hFF);
    drain();
    chk("err_parse", err, 1);
    err_pulse(1'b1, 1'b1);
    chk("err_set_over_clr", err, 1);
    err_pulse(1'b0, 1'b1);
    chk("err_clr", err, 0);
    err_pulse(1'b1, 1'b0);
    chk("err_overflow", err, 1);
    err_pulse(1'b0, 1'b1);
    chk("err_clr2", err, 0);
    p0 = pulses;
    push(8'h1C);
    drain();
    chk("err_then_make", pulses - p0, 1);

    // reset while popping: byte stays in the FIFO and is parsed once
    push(8'h5A);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midpop_nextdata_n", bus.nextdata_n, 1);
    chk("midpop_key_code", key_code, 0);
    chk("midpop_key_ext", key_ext, 0);
    chk("midpop_key_held", key_held, 0);
    chk("midpop_key_valid", key_valid, 0);
    chk("midpop_press_cnt", press_cnt, 0);
    chk("midpop_err", err, 0);
    foreach (exp_q[i]) if (exp_q[i].valid) exp_pulses--;
    exp_q.delete();
    model_reset();
    foreach (fifo_q[i]) model_byte(fifo_q[i]);
    tick(); tick();
    chk("midpop_fifo_kept", fifo_q.size(), 1);
    rst = 1'b0;
    pop_cyc.delete();
    drain();
    chk("midpop_reread_pops", pop_cyc.size(), 1);
    chk("midpop_cnt", press_cnt, 1);

    // counter wrap
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 256; i++) push((i % 2 == 0) ? 8'h15 : 8'h1D);
    drain();
    chk("wrap_cnt", press_cnt, 0);
    chk("wrap_pulses", pulses - p0, 256);

    // randomized stream with irregular arrival
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) b = 8'($urandom_range(0, 255));
      else b = pool[$urandom_range(0, 9)];
      push(b);
      repeat ($urandom_range(1, 4)) tick();
    end
    drain();

    chk("exp_queue_empty", exp_q.size(), 0);
    chk("total_pulses", pulses, exp_pulses);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scan_ctrl.md
# ps2_scan_ctrl

Controller that sequences reads from the PS/2 keyboard receiver FIFO and turns the raw scan-code byte stream into key events. It drives the FIFO pop strobe (`nextdata_n`) against the receiver's `ready`, and parses the E0 (extended) and F0 (break) prefixes. It tracks the currently held key and counts distinct key presses. It sits between `ps2_keyboard` and the display-decoding logic, replacing ad-hoc pop logic in the consumer.

## Interface
Parameters:
- `CNT_W`, default 8: width of the press counter.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ready` in 1: receiver FIFO non-empty; `data` is valid while high.
- `data` in 8: FIFO head byte.
- `overflow` in 1: receiver FIFO overflow flag.
- `nextdata_n` out 1: active-low pop strobe to the receiver.
- `key_code` out 8: scan code of the last make event.
- `key_ext` out 1: last make event carried the E0 prefix.
- `key_held` out 1: last made key not yet released.
- `key_valid` out 1: one-cycle pulse on each new make event.
- `press_cnt` out CNT_W: number of make events, wraps modulo 2^CNT_W.
- `err` out 1: sticky error flag.
- `clr_err` in 1: clears `err`.

## Operation
- Read FSM states:
  - S_IDLE: if `ready`=1 at the edge, latch `data` into `rx_byte` and go to S_POP; otherwise stay.
  - S_POP: `nextdata_n`=0 for exactly this cycle. At the edge leaving S_POP, parse `rx_byte` and go to S_GAP.
  - S_GAP: `nextdata_n`=1. This cycle lets the receiver's `ready`/`data` settle after the pop. Return to S_IDLE.
- `nextdata_n` is decoded only from state: low iff state is S_POP. It is never low in two consecutive cycles.
- Parse rules, with internal flags `ext_pend` and `brk_pend`:
  - 0xE0: set `ext_pend`; no event.
  - 0xF0: set `brk_pend`; no event.
  - 0x00 or 0xFF: discard, clear both pend flags, set `err`.
  - Any other code `c` with `brk_pend`=1 (break): if `c`==`key_code` and `ext_pend`==`key_ext`, clear `key_held`. A break for any other key is ignored. Clear both pend flags. No `key_valid` pulse.
  - Any other code `c` with `brk_pend`=0, typematic repeat case (`key_held`=1, `c`==`key_code`, `ext_pend`==`key_ext`): clear pend flags only. No pulse, no count.
  - Any other code `c` with `brk_pend`=0, new make: set `key_code`=`c`, `key_ext`=`ext_pend`, `key_held`=1, `press_cnt`+=1 (wraps all-ones to 0), pulse `key_valid`. Clear pend flags.
- `err` handling:
  - Set when `overflow`=1 on any edge, or when a 0x00/0xFF byte is parsed.
  - Cleared by `clr_err`=1.
  - Set has priority over clear in the same cycle.
- Reset values:
  - State S_IDLE, `nextdata_n`=1.
  - `key_code`=0x00, `key_ext`=0, `key_held`=0, `key_valid`=0, `press_cnt`=0, `err`=0.
  - Pend flags 0, `rx_byte`=0.
- Reset asserted during S_POP: `nextdata_n` returns to 1 asynchronously. The partially handled byte is not parsed; it remains in the receiver FIFO.

## Timing
- Byte accepted at edge N (S_IDLE with `ready`=1).
- `nextdata_n` low during cycle N..N+1.
- Parsed outputs change at edge N+1. `key_valid` is high for the cycle N+1..N+2.
- Throughput: at most one byte per 3 cycles. A back-to-back FIFO is drained at 3 cycles per byte.
- A make with the E0 prefix consumes 2 bytes and produces its event 3 cycles after the first byte is accepted plus 1 cycle. An E0-prefixed break (E0 F0 xx) consumes 3 bytes.
- `ready` is sampled only in S_IDLE. `ready` or `data` changes in S_POP or S_GAP are ignored.

## Structure
- Shared package `ps2_pkg` holds:
  - Constants `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, `PS2_ERR0`=8'h00, `PS2_ERR1`=8'hFF.
  - The read-FSM state typedef (S_IDLE, S_POP, S_GAP).
- No sub-module: the FSM and parser are one always-block pair. The receiver stays in `ps2_keyboard` unchanged.

## Test plan
- **Single make:** FIFO holds 0x1C; `ready`=1. Required: `nextdata_n` low for 1 cycle; `key_code`=0x1C, `key_ext`=0, `key_held`=1, `press_cnt`=1, one `key_valid` pulse.
- **Make, repeat, break:** bytes 1C 1C 1C F0 1C. Required: exactly one `key_valid` pulse, `press_cnt`=1, `key_held`=0 after the last byte, 3 cycles per byte.
- **Extended key:** bytes E0 75 E0 F0 75. Required: `key_code`=0x75, `key_ext`=1, `press_cnt`=1. `key_held` rises, then clears. A plain F0 75 break does not clear it.
- **Counter wrap:** with CNT_W=8, 256 alternating makes of 0x15 and 0x1D (no breaks). Required: `press_cnt` reads 0 after the 256th make, with 256 `key_valid` pulses.
- **Errors:** byte 0xFF, then `overflow` pulse, then `clr_err`.
  - Required: `err`=1 after parse; stays 1 after `clr_err` if asserted in the same cycle as `overflow`; `err`=0 after a lone `clr_err`.
  - Required: pend flags cleared, so a following 1C is a make.
- **Reset mid-pop:** assert `rst` during S_POP. Required: `nextdata_n`=1 immediately, all outputs at reset values. After release, the same byte is re-read from the FIFO and parsed once.
